// File: rtl/mem_bank_responder.sv
// -----------------------------------------------------------------------------
// mem_bank_responder
//
// Responder side of the multi-bank scratchpad interface. Each bank owns one
// read port and one write port on its own storage array. Reads return after a
// fixed RD_LAT-cycle pipeline. Accesses to addresses at or beyond DEPTH are
// reported and never touch storage.
//
// Parameters
//   NUM_BANKS  number of independent banks
//   ADDR_W     bank-local address width on the interface
//   DATA_W     word width per bank
//   DEPTH      implemented words per bank (power of two)
//   RD_LAT     read latency in cycles, 1..4
//
// Ports (bank b occupies slice [b*W +: W] of every flattened vector)
//   clk         in   clock, all logic on the rising edge
//   rst         in   synchronous reset, active high
//   read        in   per-bank read strobe
//   addr_read   in   per-bank read address
//   write       in   per-bank write strobe
//   addr_write  in   per-bank write address
//   wr_data     in   per-bank write data
//   rd_valid    out  per-bank read data valid
//   rd_data     out  per-bank read data, held while rd_valid is low
//   rd_err      out  per-bank out-of-range flag, aligned to rd_valid
//   line_done   out  one-cycle pulse when all reads of one request cycle return
//   line_cnt    out  number of banks returned together with line_done
//   err_cnt     out  saturating count of out-of-range reads and writes
// -----------------------------------------------------------------------------
module mem_bank_responder #(
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BANKS-1:0]          read,
    input  logic [NUM_BANKS*ADDR_W-1:0]   addr_read,
    input  logic [NUM_BANKS-1:0]          write,
    input  logic [NUM_BANKS*ADDR_W-1:0]   addr_write,
    input  logic [NUM_BANKS*DATA_W-1:0]   wr_data,
    output logic [NUM_BANKS-1:0]          rd_valid,
    output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
    output logic [NUM_BANKS-1:0]          rd_err,
    output logic                          line_done,
    output logic [4:0]                    line_cnt,
    output logic [15:0]                   err_cnt
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int EPOP_W = $clog2(2 * NUM_BANKS + 1);

    // Latency outside the supported range is rejected while elaborating.
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_bank_responder: RD_LAT must be in the range 1..4");
    end

    // -------------------------------------------------------------------------
    // Control pipeline: one entry per latency stage, index 0 is the stage that
    // lines up with the storage read register, index RD_LAT-1 drives outputs.
    // -------------------------------------------------------------------------
    logic [NUM_BANKS-1:0] vld_q  [RD_LAT];
    logic [NUM_BANKS-1:0] err_q  [RD_LAT];
    logic                 done_q [RD_LAT];
    logic [4:0]           cnt_q  [RD_LAT];

    logic [NUM_BANKS-1:0] rd_oor_vec;
    logic [NUM_BANKS-1:0] wr_oor_vec;

    logic [4:0]           rd_pop_d;
    logic [EPOP_W-1:0]    err_pop_d;
    logic [16:0]          err_sum_d;
    logic [15:0]          err_cnt_d;
    logic [15:0]          err_cnt_q;

    // -------------------------------------------------------------------------
    // Per-bank storage and read data path
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              rd_oor;
        logic              wr_oor;
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] ram_rd_q;
        logic              zero_sel_q;
        logic [DATA_W-1:0] stage1_data;

        assign ra = addr_read[gi*ADDR_W +: ADDR_W];
        assign wa = addr_write[gi*ADDR_W +: ADDR_W];
        assign wd = wr_data[gi*DATA_W +: DATA_W];

        // Range check sees every address bit; only the low bits index storage.
        assign rd_oor = (ra >= ADDR_W'(DEPTH));
        assign wr_oor = (wa >= ADDR_W'(DEPTH));
        assign rd_oor_vec[gi] = rd_oor;
        assign wr_oor_vec[gi] = wr_oor;

        always_ff @(posedge clk) begin
            if (!rst && write[gi] && !wr_oor) begin
                mem[wa[IDX_W-1:0]] <= wd;
            end
        end

        // Separate process from the write keeps read-first behaviour on a
        // same-address collision: the old word is captured here.
        always_ff @(posedge clk) begin
            if (!rst && read[gi] && !rd_oor) begin
                ram_rd_q <= mem[ra[IDX_W-1:0]];
            end
        end

        // The storage read register has no reset, so a separate flag decides
        // whether stage 1 shows the stored word or zero. Reset and an
        // out-of-range read both select zero; the flag only changes on a read,
        // which also makes stage 1 hold its value between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                zero_sel_q <= 1'b1;
            end else if (read[gi]) begin
                zero_sel_q <= rd_oor;
            end
        end

        assign stage1_data = zero_sel_q ? '0 : ram_rd_q;

        if (RD_LAT == 1) begin : g_lat1
            assign rd_data[gi*DATA_W +: DATA_W] = stage1_data;
        end else begin : g_latn
            logic [DATA_W-1:0] dly_q [RD_LAT-1];

            // Each delay stage loads only when the stage feeding it carries a
            // valid read, so the output word is held between responses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < RD_LAT - 1; s++) begin
                        dly_q[s] <= '0;
                    end
                end else begin
                    if (vld_q[0][gi]) begin
                        dly_q[0] <= stage1_data;
                    end
                    for (int s = 1; s < RD_LAT - 1; s++) begin
                        if (vld_q[s][gi]) begin
                            dly_q[s] <= dly_q[s-1];
                        end
                    end
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = dly_q[RD_LAT-2];
        end
    end

    // -------------------------------------------------------------------------
    // Request-cycle bookkeeping: read popcount and error popcount
    // -------------------------------------------------------------------------
    always_comb begin
        rd_pop_d  = '0;
        err_pop_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_pop_d  = rd_pop_d + 5'(read[b]);
            err_pop_d = err_pop_d + EPOP_W'(read[b] & rd_oor_vec[b])
                                  + EPOP_W'(write[b] & wr_oor_vec[b]);
        end
        // One spare bit catches the carry so the counter clamps at all-ones.
        err_sum_d = {1'b0, err_cnt_q} + 17'(err_pop_d);
        err_cnt_d = err_sum_d[16] ? 16'hFFFF : err_sum_d[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s]  <= '0;
                err_q[s]  <= '0;
                done_q[s] <= 1'b0;
                cnt_q[s]  <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            vld_q[0]  <= read;
            err_q[0]  <= read & rd_oor_vec;
            done_q[0] <= |read;
            cnt_q[0]  <= rd_pop_d;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s]  <= vld_q[s-1];
                err_q[s]  <= err_q[s-1];
                done_q[s] <= done_q[s-1];
                cnt_q[s]  <= cnt_q[s-1];
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_valid  = vld_q[RD_LAT-1];
    assign rd_err    = err_q[RD_LAT-1];
    assign line_done = done_q[RD_LAT-1];
    assign line_cnt  = cnt_q[RD_LAT-1];
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mem_bank_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bank_responder
//
// Self-checking bench for mem_bank_responder. A behavioural model (plain
// arrays plus a queue of expected responses) predicts every output each cycle;
// directed sequences and a table of single-bank vectors add explicit checks.
// -----------------------------------------------------------------------------
module tb_mem_bank_responder;

    localparam int NB    = 16;
    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NB-1:0]      read_v;
    logic [NB-1:0]      write_v;
    logic [AW-1:0]      ra [NB];
    logic [AW-1:0]      wa [NB];
    logic [DW-1:0]      wd [NB];
    logic [NB*AW-1:0]   addr_read_f;
    logic [NB*AW-1:0]   addr_write_f;
    logic [NB*DW-1:0]   wr_data_f;
    logic [NB-1:0]      rd_valid;
    logic [NB*DW-1:0]   rd_data;
    logic [NB-1:0]      rd_err;
    logic               line_done;
    logic [4:0]         line_cnt;
    logic [15:0]        err_cnt;

    always #5 clk = ~clk;

    always_comb begin
        addr_read_f  = '0;
        addr_write_f = '0;
        wr_data_f    = '0;
        for (int b = 0; b < NB; b++) begin
            addr_read_f[b*AW +: AW]  = ra[b];
            addr_write_f[b*AW +: AW] = wa[b];
            wr_data_f[b*DW +: DW]    = wd[b];
        end
    end

    mem_bank_responder #(
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .RD_LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read_v),
        .addr_read  (addr_read_f),
        .write      (write_v),
        .addr_write (addr_write_f),
        .wr_data    (wr_data_f),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .line_done  (line_done),
        .line_cnt   (line_cnt),
        .err_cnt    (err_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [NB-1:0]    mask;
        logic [NB-1:0]    err;
        logic [NB*DW-1:0] data;
    } exp_t;

    logic [DW-1:0] mem_m  [NB][DEPTH];
    logic [DW-1:0] last_m [NB];
    exp_t          exp_q  [$];
    int            err_m;
    int            checks;
    int            errors;

    typedef struct {
        int          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        read_v  = '0;
        write_v = '0;
        for (int b = 0; b < NB; b++) begin
            ra[b] = '0;
            wa[b] = '0;
            wd[b] = '0;
        end
    endtask

    // Advance one clock: predict this cycle's responses from the model,
    // apply writes read-first, then compare the outputs due this cycle.
    task automatic step();
        exp_t          r;
        int            errs;
        logic [NB*DW-1:0] last_flat;
        r.mask = '0;
        r.err  = '0;
        r.data = '0;
        errs   = 0;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(r);
            err_m = 0;
            for (int b = 0; b < NB; b++) last_m[b] = '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (read_v[b]) begin
                    r.mask[b] = 1'b1;
                    if (int'(ra[b]) < DEPTH) begin
                        r.data[b*DW +: DW] = mem_m[b][ra[b][9:0]];
                    end else begin
                        r.err[b] = 1'b1;
                        errs++;
                    end
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (write_v[b]) begin
                    if (int'(wa[b]) < DEPTH) mem_m[b][wa[b][9:0]] = wd[b];
                    else errs++;
                end
            end
            err_m = (err_m + errs > 65535) ? 65535 : err_m + errs;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        r = exp_q.pop_front();
        for (int b = 0; b < NB; b++) begin
            if (r.mask[b]) last_m[b] = r.data[b*DW +: DW];
            last_flat[b*DW +: DW] = last_m[b];
        end
        chk("rd_valid",  rd_valid,  r.mask);
        chk("rd_err",    rd_err,    r.err);
        chk("rd_data",   rd_data,   last_flat);
        chk("line_done", line_done, (r.mask != '0));
        chk("line_cnt",  line_cnt,  $countones(r.mask));
        chk("err_cnt",   err_cnt,   err_m);
    endtask

    initial begin
        int mode;
        checks = 0;
        errors = 0;
        err_m  = 0;

        vecs[0] = '{4,  19'd0,       8'h3C, 8'h3C, 1'b0};
        vecs[1] = '{15, 19'd1023,    8'hF0, 8'hF0, 1'b0};
        vecs[2] = '{7,  19'd1024,    8'hAA, 8'h00, 1'b1};
        vecs[3] = '{0,  19'h7FFFF,   8'h55, 8'h00, 1'b1};
        vecs[4] = '{11, 19'd512,     8'h00, 8'h00, 1'b0};
        vecs[5] = '{1,  19'h40001,   8'h77, 8'h00, 1'b1};
        vecs[6] = '{8,  19'd1,       8'h81, 8'h81, 1'b0};
        vecs[7] = '{13, 19'd1022,    8'hFF, 8'hFF, 1'b0};

        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        chk("reset_err_cnt", err_cnt, 16'h0000);
        chk("reset_valid", rd_valid, 16'h0000);

        // Give every storage word a defined value.
        for (int i = 0; i < DEPTH; i++) begin
            write_v = '1;
            for (int b = 0; b < NB; b++) begin
                wa[b] = AW'(i);
                wd[b] = DW'($urandom);
            end
            step();
        end
        clear_inputs();
        $display("fill: %0d words per bank written", DEPTH);

        // 1) simple write then read
        write_v[3] = 1'b1; wa[3] = 19'd5; wd[3] = 8'hA5;
        step(); clear_inputs();
        read_v[3] = 1'b1; ra[3] = 19'd5;
        step(); clear_inputs();
        step();
        chk("t1_valid3", rd_valid[3], 1'b1);
        chk("t1_data3", rd_data[3*DW +: DW], 8'hA5);
        $display("t1: bank3 addr5 rd_valid=%0d rd_data=%h", rd_valid[3], rd_data[3*DW +: DW]);

        // 2) read-first on same-address collision
        write_v[0] = 1'b1; wa[0] = 19'd7; wd[0] = 8'h22;
        step(); clear_inputs();
        write_v[0] = 1'b1; wa[0] = 19'd7; wd[0] = 8'h11;
        read_v[0] = 1'b1;  ra[0] = 19'd7;
        step(); clear_inputs();
        read_v[0] = 1'b1;  ra[0] = 19'd7;
        step(); clear_inputs();
        chk("t2_old", rd_data[0 +: DW], 8'h22);
        step();
        chk("t2_new", rd_data[0 +: DW], 8'h11);
        $display("t2: collision returned old, next read returned %h", rd_data[0 +: DW]);

        // 3) line_done / line_cnt on back-to-back request cycles
        read_v = '1;
        for (int b = 0; b < NB; b++) ra[b] = AW'($urandom_range(0, DEPTH - 1));
        step();
        read_v = 16'h000F;
        step(); clear_inputs();
        chk("t3_done_a", line_done, 1'b1);
        chk("t3_cnt_a", line_cnt, 5'd16);
        step();
        chk("t3_done_b", line_done, 1'b1);
        chk("t3_cnt_b", line_cnt, 5'd4);
        step();
        chk("t3_done_c", line_done, 1'b0);
        $display("t3: line counts 16 then 4 observed");

        // 4) out-of-range read and write in one cycle
        write_v[2] = 1'b1; wa[2] = 19'h003FF; wd[2] = 8'h5C;
        step(); clear_inputs();
        rst = 1'b1; step(); rst = 1'b0;
        read_v[9] = 1'b1;  ra[9] = 19'h00400;
        write_v[2] = 1'b1; wa[2] = 19'h7FFFF; wd[2] = 8'hEE;
        step(); clear_inputs();
        chk("t4_err_cnt", err_cnt, 16'd2);
        step();
        chk("t4_valid9", rd_valid[9], 1'b1);
        chk("t4_err9", rd_err[9], 1'b1);
        chk("t4_data9", rd_data[9*DW +: DW], 8'h00);
        read_v[2] = 1'b1; ra[2] = 19'h003FF;
        step(); clear_inputs();
        step();
        chk("t4_bank2_kept", rd_data[2*DW +: DW], 8'h5C);
        $display("t4: err_cnt=%0d bank2[3FF]=%h", err_cnt, rd_data[2*DW +: DW]);

        // 5) reset drops in-flight reads
        read_v = 16'h0006; ra[1] = 19'd1; ra[2] = 19'd2;
        step(); clear_inputs();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_valid", rd_valid, 16'h0000);
        chk("t5_data", rd_data, '0);
        chk("t5_cnt", line_cnt, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_valid", rd_valid, 16'h0000);
        end
        $display("t5: reset dropped reads on banks 1,2");

        // Table of single-bank write/read vectors
        for (int v = 0; v < 8; v++) begin
            clear_inputs();
            write_v[vecs[v].bank] = 1'b1;
            wa[vecs[v].bank] = vecs[v].addr;
            wd[vecs[v].bank] = vecs[v].wdata;
            step(); clear_inputs();
            read_v[vecs[v].bank] = 1'b1;
            ra[vecs[v].bank] = vecs[v].addr;
            step(); clear_inputs();
            step();
            chk("vec_valid", rd_valid[vecs[v].bank], 1'b1);
            chk("vec_data", rd_data[vecs[v].bank*DW +: DW], vecs[v].exp_data);
            chk("vec_err", rd_err[vecs[v].bank], vecs[v].exp_err);
            $display("vec %0d: bank=%0d addr=%h rd_data=%h rd_err=%0d", v, vecs[v].bank,
                     vecs[v].addr, rd_data[vecs[v].bank*DW +: DW], rd_err[vecs[v].bank]);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            read_v  = NB'($urandom);
            write_v = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                mode = $urandom_range(0, 4);
                case (mode)
                    0: begin ra[b] = AW'($urandom_range(0, 7)); wa[b] = AW'($urandom_range(0, 7)); end
                    1, 2: begin ra[b] = AW'($urandom_range(0, DEPTH - 1)); wa[b] = AW'($urandom_range(0, DEPTH - 1)); end
                    3: begin ra[b] = AW'($urandom_range(1000, 1100)); wa[b] = AW'($urandom_range(1000, 1100)); end
                    default: begin ra[b] = AW'($urandom); wa[b] = AW'($urandom); end
                endcase
                wd[b] = DW'($urandom);
            end
            step();
        end
        clear_inputs();
        step();
        step();
        $display("random: 400 cycles of mixed traffic applied");

        // 6) err_cnt saturation
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            read_v  = '1;
            write_v = '1;
            for (int b = 0; b < NB; b++) begin
                ra[b] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
                wa[b] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
            end
            step();
        end
        read_v  = '1;
        write_v = 16'h3FFF;
        step();
        chk("t6_near_sat", err_cnt, 16'hFFFE);
        read_v  = 16'h0007;
        write_v = '0;
        step();
        chk("t6_sat", err_cnt, 16'hFFFF);
        read_v  = '1;
        write_v = '1;
        step();
        chk("t6_sat_hold", err_cnt, 16'hFFFF);
        clear_inputs();
        step();
        step();
        $display("t6: err_cnt=%h after saturation", err_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
